// File: rtl/tnew_hazard_tracker.sv
// Carries {valid, addr, tnew} for each issued instruction down the post-decode stages
// and derives the decode stall and per-source forwarding selects from the stored entries.
module tnew_hazard_tracker #(
    parameter int  STAGES = 3,
    parameter int  TW     = 4,
    parameter int  AW     = 5,
    parameter int  NSRC   = 2,
    localparam int SW     = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 in_valid,
    input  logic [AW-1:0]        in_addr,
    input  logic [TW-1:0]        in_tnew,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC*TW-1:0]   src_tuse,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic [STAGES*TW-1:0] st_tnew
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [TW-1:0] tnew;
    } entry_t;

    entry_t stage_q [1:STAGES];
    entry_t stage_d [1:STAGES];
    logic   stall_req;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
        return (t != '0) ? t - 1'b1 : '0;
    endfunction

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        logic          found;
        logic [TW-1:0] hit_tnew;
        logic [SW-1:0] hit_k;
        logic [AW-1:0] sa;
        // NOTE: every combinationally written signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        stall_req = 1'b0;
        fwd_sel   = '0;
        found     = 1'b0;
        hit_tnew  = '0;
        hit_k     = '0;
        sa        = '0;
        for (int i = 0; i < NSRC; i++) begin
            found    = 1'b0;
            hit_tnew = '0;
            hit_k    = '0;
            sa       = src_addr[i*AW +: AW];
            for (int k = STAGES; k >= 1; k--) begin
                if (stage_q[k].valid && stage_q[k].addr == sa && sa != '0) begin
                    found    = 1'b1;
                    hit_tnew = stage_q[k].tnew;
                    hit_k    = SW'(k);
                end
            end
            if (found && hit_tnew > src_tuse[i*TW +: TW]) begin
                stall_req = 1'b1;
            end
            if (found && hit_tnew == '0) begin
                fwd_sel[i*SW +: SW] = hit_k;
            end
        end
    end

    assign stall = hold | stall_req;

    always_comb begin
        st_tnew = '0;
        for (int k = 1; k <= STAGES; k++) begin
            st_tnew[(k-1)*TW +: TW] = stage_q[k].tnew;
        end
    end

    // A stalled decode instruction is not captured; a bubble enters stage 1 instead.
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (!hold) begin
            stage_d[1] = stall ? '0 : entry_t'{valid: in_valid, addr: in_addr, tnew: in_tnew};
            for (int k = 2; k <= STAGES; k++) begin
                stage_d[k]      = stage_q[k-1];
                stage_d[k].tnew = dec(stage_q[k-1].tnew);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every stage is reset, because a stale valid entry would match a source and stall or forward wrongly.
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so all stages sample the pre-edge values together.
            for (int k = 1; k <= STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_tnew_hazard_tracker.sv
// Bench for tnew_hazard_tracker: directed vector table, hand-written reset sequence,
// then randomized traffic against an age-based reference model.
module tb_tnew_hazard_tracker;

    localparam int STAGES = 3;
    localparam int TW     = 4;
    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int SW     = 2;

    logic                 clk;
    logic                 reset;
    logic                 hold;
    logic                 in_valid;
    logic [AW-1:0]        in_addr;
    logic [TW-1:0]        in_tnew;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC*TW-1:0]   src_tuse;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [STAGES*TW-1:0] st_tnew;

    int checks   = 0;
    int failures = 0;

    tnew_hazard_tracker #(
        .STAGES (STAGES),
        .TW     (TW),
        .AW     (AW),
        .NSRC   (NSRC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_tnew  (in_tnew),
        .src_addr (src_addr),
        .src_tuse (src_tuse),
        .stall    (stall),
        .fwd_sel  (fwd_sel),
        .st_tnew  (st_tnew)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic h, input logic iv, input logic [AW-1:0] ia, input logic [TW-1:0] it,
                         input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [TW-1:0] u0, input logic [TW-1:0] u1);
        hold     = h;
        in_valid = iv;
        in_addr  = ia;
        in_tnew  = it;
        src_addr = {s1, s0};
        src_tuse = {u1, u0};
    endtask

    // One table row: inputs applied in a cycle and the outputs expected before its closing edge.
    typedef struct {
        logic          h;
        logic          iv;
        logic [AW-1:0] ia;
        logic [TW-1:0] it;
        logic [AW-1:0] s0;
        logic [AW-1:0] s1;
        logic [TW-1:0] u0;
        logic [TW-1:0] u1;
        logic          stall;
        logic [SW-1:0] f0;
        logic [SW-1:0] f1;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [TW-1:0] t3;
    } vec_t;

    function automatic vec_t mk(input int h, input int iv, input int ia, input int it,
                                input int s0, input int s1, input int u0, input int u1,
                                input int st, input int f0, input int f1,
                                input int t1, input int t2, input int t3);
        vec_t v;
        v.h = h[0]; v.iv = iv[0]; v.ia = ia[AW-1:0]; v.it = it[TW-1:0];
        v.s0 = s0[AW-1:0]; v.s1 = s1[AW-1:0]; v.u0 = u0[TW-1:0]; v.u1 = u1[TW-1:0];
        v.stall = st[0]; v.f0 = f0[SW-1:0]; v.f1 = f1[SW-1:0];
        v.t1 = t1[TW-1:0]; v.t2 = t2[TW-1:0]; v.t3 = t3[TW-1:0];
        return v;
    endfunction

    // Reference model: each slot keeps the tnew it had on entering stage 1; the
    // current tnew follows from how many hops the slot position implies.
    logic          m_valid [1:STAGES];
    logic [AW-1:0] m_addr  [1:STAGES];
    int            m_born  [1:STAGES];

    function automatic int m_tnew(input int k);
        return (m_born[k] > k - 1) ? m_born[k] - (k - 1) : 0;
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= STAGES; k++) begin
            m_valid[k] = 1'b0;
            m_addr[k]  = '0;
            m_born[k]  = 0;
        end
    endtask

    task automatic model_eval(output logic e_stall, output logic [NSRC*SW-1:0] e_fwd,
                              output logic [STAGES*TW-1:0] e_tnew);
        e_stall = hold;
        e_fwd   = '0;
        e_tnew  = '0;
        for (int k = 1; k <= STAGES; k++) begin
            e_tnew[(k-1)*TW +: TW] = TW'(m_tnew(k));
        end
        for (int i = 0; i < NSRC; i++) begin
            int hit;
            logic [AW-1:0] sa;
            hit = 0;
            sa  = src_addr[i*AW +: AW];
            for (int k = 1; k <= STAGES; k++) begin
                if (hit == 0 && sa != 0 && m_valid[k] && m_addr[k] == sa) hit = k;
            end
            if (hit != 0) begin
                if (m_tnew(hit) > int'(src_tuse[i*TW +: TW])) e_stall = 1'b1;
                if (m_tnew(hit) == 0) e_fwd[i*SW +: SW] = SW'(hit);
            end
        end
    endtask

    task automatic model_advance(input logic e_stall);
        if (!hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1];
                m_addr[k]  = m_addr[k-1];
                // Age is positional, so moving a slot one stage implies one decrement.
                m_born[k]  = m_born[k-1];
            end
            if (e_stall) begin
                m_valid[1] = 1'b0;
                m_addr[1]  = '0;
                m_born[1]  = 0;
            end else begin
                m_valid[1] = in_valid;
                m_addr[1]  = in_addr;
                m_born[1]  = int'(in_tnew);
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic e_stall;
        logic [NSRC*SW-1:0] e_fwd;
        logic [STAGES*TW-1:0] e_tnew;

        // Load-use
        vecs.push_back(mk(0,1,8,2,  0,0,0,0,   0,0,0, 0,0,0));
        vecs.push_back(mk(0,1,1,0,  8,0,0,0,   1,0,0, 2,0,0));
        vecs.push_back(mk(0,1,1,0,  8,0,0,0,   1,0,0, 0,1,0));
        vecs.push_back(mk(0,1,1,0,  8,0,0,0,   0,3,0, 0,0,0));
        // ALU forward
        vecs.push_back(mk(0,1,5,1,  0,0,0,0,   0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0,0,  0,5,0,1,   0,0,0, 1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,5,0,1,   0,0,2, 0,0,0));
        // Youngest priority and register 0
        vecs.push_back(mk(0,1,3,0,  0,0,0,0,   0,0,0, 0,0,0));
        vecs.push_back(mk(0,1,3,0,  3,0,0,0,   0,1,0, 0,0,0));
        vecs.push_back(mk(0,1,0,3,  3,0,0,0,   0,1,0, 0,0,0));
        vecs.push_back(mk(0,0,0,0,  3,0,0,0,   0,2,0, 3,0,0));
        // Hold
        vecs.push_back(mk(0,1,9,3,  0,0,0,0,   0,0,0, 0,2,0));
        vecs.push_back(mk(1,0,0,0,  9,0,0,0,   1,0,0, 3,0,1));
        vecs.push_back(mk(1,0,0,0,  9,0,0,0,   1,0,0, 3,0,1));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,   0,0,0, 3,0,1));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,   0,0,0, 0,2,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,   0,0,0, 0,0,1));
        // Saturation, plus tuse == tnew and tuse < tnew boundaries
        vecs.push_back(mk(0,1,4,0,  0,0,0,0,   0,0,0, 0,0,0));
        vecs.push_back(mk(0,1,6,15, 0,0,0,0,   0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,0,0,  4,6,0,15,  0,2,0, 15,0,0));
        vecs.push_back(mk(0,0,0,0,  4,6,0,13,  1,3,0, 0,14,0));
        vecs.push_back(mk(0,0,0,0,  6,6,13,13, 0,0,0, 0,0,13));

        // Power-up reset, with hold high to see stall follow it.
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_st_tnew", 32'(st_tnew), 32'h0);
        check("reset_fwd", 32'(fwd_sel), 32'h0);
        check("reset_stall_eq_hold", 32'(stall), 32'h1);
        hold = 1'b0;
        #1;
        check("reset_stall_low", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].h, vecs[n].iv, vecs[n].ia, vecs[n].it,
                  vecs[n].s0, vecs[n].s1, vecs[n].u0, vecs[n].u1);
            #1;
            check($sformatf("vec%0d_stall", n), 32'(stall), 32'(vecs[n].stall));
            check($sformatf("vec%0d_fwd", n), 32'(fwd_sel), 32'({vecs[n].f1, vecs[n].f0}));
            check($sformatf("vec%0d_st_tnew", n), 32'(st_tnew),
                  32'({vecs[n].t3, vecs[n].t2, vecs[n].t1}));
        end

        // Mid-operation asynchronous reset with address 7 in flight.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            drive(0, 1, 7, 2, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 7, 0, 0, 0);
        #1;
        check("prereset_stall", 32'(stall), 32'h1);
        check("prereset_st_tnew", 32'(st_tnew), 32'h012);
        reset = 1'b1;
        #1;
        check("midreset_st_tnew", 32'(st_tnew), 32'h0);
        check("midreset_stall", 32'(stall), 32'h0);
        check("midreset_fwd", 32'(fwd_sel), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? TW'($urandom_range(0, 15)) : TW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)),
                  TW'($urandom_range(0, 3)),
                  TW'($urandom_range(0, 3)));
            #1;
            model_eval(e_stall, e_fwd, e_tnew);
            check("rand_stall", 32'(stall), 32'(e_stall));
            check("rand_fwd", 32'(fwd_sel), 32'(e_fwd));
            check("rand_st_tnew", 32'(st_tnew), 32'(e_tnew));
            if (n == 1000) begin
                reset = 1'b1;
                drive(0, 0, 0, 0, 0, 0, 0, 0);
                #1;
                model_clear();
                check("rand_reset_st_tnew", 32'(st_tnew), 32'h0);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                model_advance(e_stall);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
